mips_cpu_muldiv: RTL

Multi-cycle multiply/divide unit that owns the architectural HI/LO registers for the MIPS CPU. It sits directly downstream of the ALU's register-operand path and takes over MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ALU. Its hi/lo outputs feed the ALU's MFHI/MFLO result path. The control unit stalls the pipeline while busy is high.

---
 rtl/mips_cpu_muldiv_pkg.sv | 28 ++
 rtl/mips_cpu_muldiv_signfix.sv | 32 +++
 rtl/mips_cpu_muldiv.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states
// and the default datapath width.
package mips_cpu_muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    // Signed ops work on magnitudes and need a sign fix-up afterwards.
    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_signfix.sv
// Combinational sign handling: operand magnitudes on entry and result
// negation in the FIX cycle. Pure wiring, no state.
module mips_cpu_muldiv_signfix
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic [WIDTH-1:0]   a_mag_o,
    output logic [WIDTH-1:0]   b_mag_o,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   quot_i,
    input  logic [WIDTH-1:0]   rem_i,
    input  logic               neg_res_i,
    input  logic               neg_rem_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   quot_o,
    output logic [WIDTH-1:0]   rem_o
);

    // Unsigned ops pass operands through untouched.
    assign a_mag_o = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag_o = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    // Flags are only ever set for signed ops, so no op check is needed here.
    assign prod_o  = neg_res_i ? -prod_i : prod_i;
    assign quot_o  = neg_res_i ? -quot_i : quot_i;
    assign rem_o   = neg_rem_i ? -rem_i  : rem_i;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator;
// one result bit is produced per CALC cycle, then FIX applies signs.
module mips_cpu_muldiv
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    md_op_e             op_q, op_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // mult: {partial, multiplier}; div: {rem, quot}
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic               in_signed, is_mult;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;

    assign in_signed = op_is_signed(md_op_e'(op));
    assign is_mult   = (op_q == MD_MULT) || (op_q == MD_MULTU);

    mips_cpu_muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .a_i       (a),
        .b_i       (b),
        .signed_i  (in_signed),
        .a_mag_o   (a_mag),
        .b_mag_o   (b_mag),
        .prod_i    (acc_q),
        .quot_i    (acc_q[WIDTH-1:0]),
        .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
        .neg_res_i (neg_res_q),
        .neg_rem_i (neg_rem_q),
        .prod_o    (prod_fix),
        .quot_o    (quot_fix),
        .rem_o     (rem_fix)
    );

    // Multiply step: add multiplicand into the upper half, keeping the carry.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    // Divide step: remainder shifted left needs one extra bit before the trial subtract.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};

    // Next-state, counter and datapath update for the four-state sequencer.
    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a variable unassigned, which would infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            op_d      = md_op_e'(op);
                            neg_res_d = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_d = in_signed & a[WIDTH-1];
                            cnt_d     = CNT_W'(WIDTH - 1);
                            state_d   = CALC;
                            if ((op == MD_MULT) || (op == MD_MULTU)) begin
                                opnd_d = a_mag;
                                acc_d  = {{WIDTH{1'b0}}, b_mag};
                            end else begin
                                opnd_d = b_mag;
                                acc_d  = {{WIDTH{1'b0}}, a_mag};
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (is_mult) begin
                    acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                                     : {1'b0, acc_q[2*WIDTH-1:1]};
                end else begin
                    acc_d = div_diff[WIDTH+1]
                          ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                          : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (is_mult) begin
                    {hi_d, lo_d} = prod_fix;
                end else begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= MD_MULT;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
